// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Register-file write-back arbiter. ALU results always win;
//               load results wait in a circular FIFO. A starvation counter
//               raises stall_req so that the queued loads can drain.
//               Optional macro WB_FWD_EN adds a same-cycle bypass output.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter  int NUM_REGS   = 32,
    parameter  int LQ_DEPTH   = 2,
    parameter  int STARVE_MAX = 4,
    parameter  int DATA_W     = 32,
    localparam int RW         = $clog2(NUM_REGS),
    localparam int CW         = $clog2(LQ_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [RW-1:0]     alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [RW-1:0]     ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              we,
    output logic [RW-1:0]     rd,
    output logic [DATA_W-1:0] wr_data,
    output logic              stall_req,
    output logic [CW-1:0]     lq_count
`ifdef WB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [RW-1:0]     fwd_rd,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam int              c_PW         = $clog2(LQ_DEPTH);
    localparam int              c_SW         = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]   c_DEPTH      = CW'(LQ_DEPTH);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_MAX);

    logic [RW-1:0]     r_lq_rd   [LQ_DEPTH];
    logic [DATA_W-1:0] r_lq_data [LQ_DEPTH];
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [c_SW-1:0]   r_starve;
    logic              r_stall;
    logic              r_we;
    logic [RW-1:0]     r_rd;
    logic [DATA_W-1:0] r_wr_data;

    logic              w_push;
    logic              w_pop;
    logic              w_sel_valid;
    logic [RW-1:0]     w_sel_rd;
    logic [DATA_W-1:0] w_sel_data;
    logic [c_SW-1:0]   w_starve_nxt;

    // Readiness looks only at current occupancy, never at a same-cycle pop.
    assign ld_ready  = (r_count < c_DEPTH);
    assign lq_count  = r_count;
    assign we        = r_we;
    assign rd        = r_rd;
    assign wr_data   = r_wr_data;
    assign stall_req = r_stall;

    always_comb begin
        w_push       = ld_valid && ld_ready;
        w_pop        = !alu_valid && (r_count != '0);
        w_sel_valid  = alu_valid || w_pop;
        w_sel_rd     = alu_valid ? alu_rd   : r_lq_rd[r_rd_ptr];
        w_sel_data   = alu_valid ? alu_data : r_lq_data[r_rd_ptr];
        w_starve_nxt = '0;
        if (alu_valid && (r_count != '0)) begin
            w_starve_nxt = (r_starve == c_STARVE_MAX) ? r_starve : r_starve + 1'b1;
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid = w_sel_valid && (w_sel_rd != '0);
    assign fwd_rd    = w_sel_rd;
    assign fwd_data  = w_sel_data;
`endif

    // Queue storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_lq_rd[r_wr_ptr]   <= ld_rd;
            r_lq_data[r_wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_starve  <= '0;
            r_stall   <= 1'b0;
            r_we      <= 1'b0;
            r_rd      <= '0;
            r_wr_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            r_starve <= w_starve_nxt;
            r_stall  <= (w_starve_nxt == c_STARVE_MAX);
            // Destination 0 is consumed silently; rd/wr_data still track it.
            r_we     <= w_sel_valid && (w_sel_rd != '0);
            if (w_sel_valid) begin
                r_rd      <= w_sel_rd;
                r_wr_data <= w_sel_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of architectural registers; index width RW = $clog2(NUM_REGS).
REQ-002 SHALL have parameter LQ_DEPTH, default 2, load-result queue entries (power of two, >= 2).
REQ-003 SHALL have parameter STARVE_MAX, default 4, consecutive cycles a waiting load may lose arbitration before a stall request.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 alu_valid  input  1  ALU result present this cycle; no backpressure.
REQ-007 alu_rd  input  RW  ALU destination register.
REQ-008 alu_data  input  data_t  ALU result.
REQ-009 ld_valid  input  1  load result offered.
REQ-010 ld_ready  output  1  queue can accept a load result this cycle.
REQ-011 ld_rd  input  RW  load destination register.
REQ-012 ld_data  input  data_t  load result.
REQ-013 we  output  1  register-file write enable, registered.
REQ-014 rd  output  RW  register-file write index, registered.
REQ-015 wr_data  output  data_t  register-file write data, registered.
REQ-016 stall_req  output  1  upstream SHALL withhold alu_valid the following cycle.
REQ-017 lq_count  output  $clog2(LQ_DEPTH)+1  current queue occupancy.

Function
REQ-018 Load handshake: transfer when ld_valid && ld_ready; ld_ready = (lq_count < LQ_DEPTH), independent of a same-cycle pop.
REQ-019 Accepted loads SHALL enter a circular FIFO; pointers wrap modulo LQ_DEPTH; order preserved.
REQ-020 Per cycle selection: alu_valid wins; else queue head popped if lq_count > 0; else nothing selected.
REQ-021 Selected entry SHALL appear on we/rd/wr_data on the next rising edge (ALU latency 1; load latency 2 from acceptance minimum).
REQ-022 Selected entry with destination 0 SHALL be consumed but produce we = 0; rd/wr_data still update.
REQ-023 No selection: we = 0; rd and wr_data hold previous values.
REQ-024 Simultaneous push and pop SHALL leave lq_count unchanged and both operations take effect.
REQ-025 Starvation counter SHALL increment each cycle lq_count > 0 and alu_valid = 1, clear on any queue pop or when queue empty, saturate at STARVE_MAX.
REQ-026 stall_req SHALL be registered, high the cycle after the counter reaches STARVE_MAX, low after the next queue pop.
REQ-027 alu_valid asserted while stall_req is high SHALL still win arbitration (protocol violation, defined result).

Reset
REQ-028 On reset assertion, asynchronously: we = 0, rd = 0, wr_data = 0, stall_req = 0, queue emptied (lq_count = 0, pointers 0), starvation counter 0.
REQ-029 Queued loads present at reset mid-operation SHALL be discarded with no write issued.
REQ-030 ld_ready SHALL be 1 while reset is high and the cycle after release.

Configuration
REQ-031 Macro WB_FWD_EN, when defined, SHALL add outputs fwd_valid (1), fwd_rd (RW), fwd_data (data_t), combinationally equal to this cycle's selection (fwd_valid = selected && rd != 0), for same-cycle bypass into register read ports.
REQ-032 Without WB_FWD_EN, these ports and their logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 alu_valid=1, alu_rd=5, alu_data=0x1234 at cycle N, queue empty -> we=1, rd=5, wr_data=0x1234 at N+1.
REQ-034 Load rd=7 data=0xAA accepted at N with alu_valid=0 throughout -> we=1, rd=7, wr_data=0xAA at N+2.
REQ-035 alu_valid=1 continuous, three loads offered, LQ_DEPTH=2 -> ld_ready=0 after two accepts, lq_count=2, stall_req=1 after 4 losing cycles; drop alu_valid -> loads written in order, stall_req clears.
REQ-036 alu_rd=0 alu_valid=1 -> we=0 next cycle; load with ld_rd=0 -> popped, we=0, lq_count decrements.
REQ-037 Reset pulsed with lq_count=2 -> lq_count=0, we=0 immediately, no queued write ever issued.
REQ-038 WB_FWD_EN defined, alu_valid=1 alu_rd=3 alu_data=0x55 -> fwd_valid=1, fwd_rd=3, fwd_data=0x55 same cycle.
